display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan scheduler for the stopwatch's common-anode 7-segment display. It shares a single segment bus among NUM_DIGITS digit selects, one fixed-length slot per digit. Each slot has an anti-ghosting blanking interval followed by a PWM-dimmed drive phase. Display inputs are latched once per frame (tear-free), with optional leading-zero suppression and per-digit decimal points.

Parameters:
NUM_DIGITS, 4, digits scanned; 1..8
SLOT_CYCLES, 40000, clocks per digit slot
BLANK_CYCLES, 8000, clocks at slot start with all selects off; constraint: 1 <= BLANK_CYCLES < SLOT_CYCLES, and (SLOT_CYCLES-BLANK_CYCLES) a multiple of 16

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
number  in  NUM_DIGITS*4  hex nibble per digit; nibble k drives digit k (digit 0 is rightmost)
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
lz_en  in  1  leading-zero suppression enable
brightness  in  4  PWM duty: 0 = off, 15 = 15/16
io_sel  out  NUM_DIGITS  digit selects, active low
io_seg  out  8  segments, active low; [7]=dp, [6:0]=g..a
frame_start  out  1  one-clock pulse when a new frame snapshot is taken

Behaviour:
- Reset: io_sel all 1, io_seg 8'hFF, frame_start 0, digit index 0, slot counter 0, PWM counter 0, shadow registers 0.
- Counters:
  - slot_cnt runs 0..SLOT_CYCLES-1 and wraps; on wrap, the digit index advances 0..NUM_DIGITS-1 and wraps.
  - Frame length is NUM_DIGITS*SLOT_CYCLES clocks.
- Snapshot: on the cycle with digit index 0 and slot_cnt 0 (including the first cycle after reset release), number, dp_in, lz_en and brightness are loaded into shadow registers. frame_start pulses on that cycle. Input changes at any other time are ignored until the next snapshot.
- Two-state FSM per slot:
  - BLANK (slot_cnt < BLANK_CYCLES): io_sel all 1, io_seg 8'hFF.
  - DRIVE: the PWM counter (4-bit) resets to 0 on entry and increments every clock, wrapping. The select for the current digit is asserted (0) only while pwm_cnt < shadow brightness and the digit is not suppressed. When the select is deasserted, io_seg = 8'hFF.
- Leading-zero suppression, when shadow lz_en = 1: digit k is suppressed if its nibble and all higher nibbles are 0. Digit 0 is never suppressed. A suppressed digit's slot keeps io_sel all 1 and its dp is not shown.
- Segment data = glyph(nibble) with bit 7 = ~dp.
  - Glyphs are hex 0-F, e.g. 0 = 7'h40, 1 = 7'h79, 4 = 7'h19, 8 = 7'h00.
- Outputs are registered: io_sel/io_seg reflect counter state with one clock of latency. frame_start is registered with the same alignment as io_sel, so it is asserted during the first cycle of the frame's output.
- Only one select is ever low at a time. Slot and frame timing are independent of brightness and suppression.
- rst asserted mid-slot: the next cycle's outputs take reset values. After release, the scan restarts at digit 0 with a new snapshot.
- NUM_DIGITS = 1: the digit index stays 0, and every slot is a frame.

Decomposition:
- Shared package: the hex-to-active-low glyph table (16 constants), the segment bit-order constants, and the BLANK/DRIVE state encoding.
- One sub-module: hex_seg_n, a combinational 4-bit nibble to 7-bit active-low glyph decoder, instantiated once on the selected shadow nibble.

Test Plan:
All scenarios use NUM_DIGITS=4, SLOT_CYCLES=40, BLANK_CYCLES=8, which gives a drive phase of 32 clocks and a frame of 160 clocks.
- Basic scan: number=16'h1234, brightness=15, dp_in=0, lz_en=0 -> slots show io_sel 1110/1101/1011/0111 with io_seg C-glyphs of 4/3/2/1 (4 -> 8'h99). Each slot has 8 blank clocks, then 30 of 32 drive clocks low. frame_start pulses every 160 clocks.
- Dimming: brightness=0 -> io_sel stays 4'hF for a whole frame. brightness=1 -> exactly 2 select-low clocks per slot, at drive offsets 0 and 16.
- Leading zeros: lz_en=1, number=16'h0050 -> digits 3 and 2 show io_sel 4'hF throughout; digit 1 shows 5 and digit 0 shows 0. number=16'h0000 -> only digit 0 lit, showing 8'hC0.
- Tear-free update: number changes from 16'h1111 to 16'h2222 at frame clock 50 -> digits 1-3 of that frame still show 1. All digits show 2 only from the next frame_start.
- Decimal point: dp_in=4'b0100, number=16'h8888 -> io_seg=8'h00 during digit 2 drive, and 8'h80 for the other digits.
- Reset mid-drive: rst high for 1 clock at frame clock 20 -> next cycle io_sel=4'hF and io_seg=8'hFF. After release, frame_start pulses and digit 0 is driven first, 9 clocks later.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: glyph table, segment bit order, slot states.
// Pure constants and types; no logic.
// No flow control involved.
package display_scan_ctrl_pkg;

    // Segment bus bit positions (active low): [7]=dp, [6:0]=g..a
    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-low glyphs for hex 0..F, bit order g..a
    localparam logic [6:0] GLYPH_N [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hex_seg_n.sv
// Hex nibble to active-low 7-segment glyph decoder.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its input).
module hex_seg_n
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = GLYPH_N[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of a common-anode 7-segment display with blanking, PWM dimming and LZ suppression.
// Latency: io_sel/io_seg/frame_start are registered, one clock after the scan counter state they reflect.
// Backpressure: none; free-running scan, inputs are sampled only at the frame snapshot.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 40000,
    parameter int BLANK_CYCLES = 8000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*4-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   io_sel,
    output logic [7:0]              io_seg,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [IDX_W-1:0]       digit_idx;
    logic [CNT_W-1:0]       slot_cnt;
    logic [3:0]             pwm_cnt;

    logic [3:0]             nib_sh [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  dp_sh;
    logic                   lz_sh;
    logic [3:0]             bright_sh;

    logic                   slot_wrap;
    logic                   snap;
    logic [NUM_DIGITS-1:0]  supp;
    logic                   zero_above;
    logic                   lit;
    logic [6:0]             glyph_n;
    logic [NUM_DIGITS-1:0]  sel_d;
    logic [7:0]             seg_d;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign snap      = (digit_idx == '0) && (slot_cnt == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (slot_cnt == BLANK_LAST) state_d = ST_DRIVE;
            ST_DRIVE: if (slot_wrap)              state_d = ST_BLANK;
            default:                              state_d = ST_BLANK;
        endcase
    end

    // A digit is suppressed when it and every higher nibble are zero; digit 0 always shows.
    always_comb begin
        zero_above = 1'b1;
        supp       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (nib_sh[k] == 4'h0);
            supp[k]    = lz_sh && zero_above && (k != 0);
        end
    end

    hex_seg_n u_hex_seg_n (
        .nibble (nib_sh[digit_idx]),
        .seg_n  (glyph_n)
    );

    always_comb begin
        sel_d = '1;
        seg_d = 8'hFF;
        lit   = (state_q == ST_DRIVE) && (pwm_cnt < bright_sh) && !supp[digit_idx];
        if (lit) begin
            sel_d[digit_idx]   = 1'b0;
            seg_d[SEG_G:SEG_A] = glyph_n;
            seg_d[SEG_DP]      = ~dp_sh[digit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BLANK;
            digit_idx   <= '0;
            slot_cnt    <= '0;
            pwm_cnt     <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) nib_sh[k] <= '0;
            dp_sh       <= '0;
            lz_sh       <= 1'b0;
            bright_sh   <= '0;
            io_sel      <= '1;
            io_seg      <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end
            // PWM phase restarts at every drive entry so each slot sees the same duty pattern
            pwm_cnt <= (state_q == ST_BLANK) ? 4'h0 : pwm_cnt + 4'h1;
            if (snap) begin
                for (int k = 0; k < NUM_DIGITS; k++) nib_sh[k] <= number[k*4 +: 4];
                dp_sh     <= dp_in;
                lz_sh     <= lz_en;
                bright_sh <= brightness;
            end
            io_sel      <= sel_d;
            io_seg      <= seg_d;
            frame_start <= snap;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: reference model predicts every output cycle from frame arithmetic.
module tb_display_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 40;
    localparam int BC    = 8;
    localparam int FRAME = ND * SC;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] number;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  brightness;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;
    logic        frame_start;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          t     = 0;
    logic [15:0] s_num;
    logic [3:0]  s_dp;
    logic [3:0]  s_br;
    logic        s_lz;
    logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .number      (number),
        .dp_in       (dp_in),
        .lz_en       (lz_en),
        .brightness  (brightness),
        .io_sel      (io_sel),
        .io_seg      (io_seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Expected output after an edge, from position within the frame since reset release
    task automatic model_edge(input logic r);
        exp_t e;
        int   pos, dig, off;
        e.sel = 4'hF;
        e.seg = 8'hFF;
        e.fs  = 1'b0;
        if (r) begin
            t = 0;
        end else begin
            pos = t % FRAME;
            dig = pos / SC;
            off = pos % SC;
            if (pos == 0) begin
                s_num = number;
                s_dp  = dp_in;
                s_lz  = lz_en;
                s_br  = brightness;
                e.fs  = 1'b1;
            end
            if (off >= BC && ((off - BC) % 16) < int'(s_br)
                && !(s_lz && dig != 0 && (s_num >> (4 * dig)) == 16'h0)) begin
                e.sel[dig] = 1'b0;
                e.seg      = {~s_dp[dig], glyph[s_num[4*dig +: 4]]};
            end
            t++;
        end
        q.push_back(e);
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("io_sel", {4'h0, io_sel}, {4'h0, e.sel});
                chk("io_seg", io_seg, e.seg);
                chk("frame_start", {7'h0, frame_start}, {7'h0, e.fs});
            end
        end
    end

    initial begin : driver
        logic [15:0] r16;
        rst        = 1'b1;
        number     = 16'h1234;
        dp_in      = 4'h0;
        lz_en      = 1'b0;
        brightness = 4'd15;
        repeat (3) step(1'b1);

        // Basic scan, then dimming extremes
        repeat (2 * FRAME) step(1'b0);
        brightness = 4'd0;
        repeat (FRAME) step(1'b0);
        brightness = 4'd1;
        repeat (FRAME) step(1'b0);

        // Leading-zero suppression
        brightness = 4'd15;
        lz_en      = 1'b1;
        number     = 16'h0050;
        repeat (FRAME) step(1'b0);
        number = 16'h0000;
        repeat (FRAME) step(1'b0);

        // Tear-free update mid-frame
        lz_en  = 1'b0;
        number = 16'h1111;
        repeat (50) step(1'b0);
        number = 16'h2222;
        repeat (2 * FRAME - 50) step(1'b0);

        // Decimal point
        dp_in  = 4'b0100;
        number = 16'h8888;
        repeat (FRAME) step(1'b0);

        // Reset mid-drive at frame clock 20
        repeat (20) step(1'b0);
        step(1'b1);
        repeat (FRAME) step(1'b0);

        // Randomized inputs changing at random times, with occasional resets
        for (int seg_i = 0; seg_i < 24; seg_i++) begin
            r16        = 16'($urandom);
            number     = r16 >> (4 * $urandom_range(0, 4));
            dp_in      = 4'($urandom_range(0, 15));
            lz_en      = 1'($urandom_range(0, 1));
            brightness = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 300)) step(1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step(1'b1);
        end
        repeat (FRAME) step(1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
